// File: rtl/mux_gate_scheduler_if.sv
// mux_gate_scheduler_if: request/response bundle between gate requesters and the mux scheduler
interface mux_gate_scheduler_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req_valid, req_ready, req_a, req_b, rsp_valid;
  logic [3*N_REQ-1:0] req_op;
  logic rsp_y, busy;
  modport master (output req_valid, req_op, req_a, req_b, input req_ready, rsp_valid, rsp_y, busy);
  modport slave (input req_valid, req_op, req_a, req_b, output req_ready, rsp_valid, rsp_y, busy);
endinterface

// File: rtl/mux_gate_scheduler.sv
// mux_gate_scheduler: round-robin time-sharing of one mux2to1 cell for two-input gate evaluations
module mux2to1 (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module mux_gate_scheduler #(parameter int N_REQ = 4) (
  input logic clk,
  input logic rst,
  mux_gate_scheduler_if.slave bus
);
  localparam int W = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] ptr, g, gnt;
  logic gnt_ok;
  logic [2:0] op;
  logic [1:0] code;
  logic a, b, t, m_sel, m_a, m_b, m_y;
  // lowest offset from ptr wins, so scan offsets downward and let the last hit stand
  always_comb begin
    gnt_ok = 1'b0;
    gnt = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
        gnt_ok = 1'b1;
        gnt = W'((int'(ptr) + k) % N_REQ);
      end
  end
  assign bus.req_ready = (state == IDLE && !rst && gnt_ok) ? (N_REQ'(1) << gnt) : '0;
  // NAND/NOR reuse the AND/OR first pass
  assign code = op[2] ? {1'b1, op[0]} : op[1:0];
  always_comb begin
    m_sel = a;
    m_a = 1'b0;
    m_b = 1'b0;
    if (state == PASS1 && op[2:1] == 2'b11) begin
      m_sel = b;
      m_a = 1'b1;
    end else if (state == PASS1) begin
      m_a = code == 2'b11 ? b : code == 2'b01;
      m_b = code == 2'b10 ? b : code != 2'b01;
    end else if (state == PASS2 && !op[1]) begin
      m_sel = t;
      m_a = 1'b1;
    end else if (state == PASS2) begin
      m_a = op[0] ? t : b;
      m_b = op[0] ? b : t;
    end
  end
  mux2to1 u_mux (.sel(m_sel), .a(m_a), .b(m_b), .y(m_y));
  always_comb
    state_nxt = state == IDLE  ? (gnt_ok ? PASS1 : IDLE) :
                state == PASS1 ? (op[2] ? PASS2 : DONE) :
                state == PASS2 ? DONE : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      op <= '0;
      a <= 1'b0;
      b <= 1'b0;
      t <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_y <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_nxt;
      bus.busy <= state_nxt != IDLE;
      bus.rsp_valid <= state_nxt == DONE ? (N_REQ'(1) << g) : '0;
      if (state_nxt == DONE) bus.rsp_y <= m_y;
      if (state == PASS1 || state == PASS2) t <= m_y;
      if (state == IDLE && gnt_ok) begin
        g <= gnt;
        op <= bus.req_op[3*gnt +: 3];
        a <= bus.req_a[gnt];
        b <= bus.req_b[gnt];
      end
      if (state == DONE) ptr <= g == W'(N_REQ - 1) ? '0 : g + 1'b1;
    end
endmodule
